multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Multi-cycle controller sequencing the RV32I-subset datapath driven by the instruction decoder.
//  Consumes the decoded op/funct3/funct7 fields and the ALU zero flag.
//  Drives the PC, IR, memory, register-file and ALU-mux strobes state by state.
//  Supports lw, sw, R-type, I-type ALU, beq and jal; memory accesses stall on mem_ready.
// PARAMETERS
//  OPCODE_WIDTH  7  opcode field width
//  FUNCT3_WIDTH  3  funct3 field width
//  FUNCT7_WIDTH  7  funct7 field width
//  STATE_WIDTH   4  state register / debug port width
// PORTS
//  clk            in   1  system clock, rising edge
//  rst_n          in   1  asynchronous active-low reset
//  op             in   7  decoded opcode
//  funct3         in   3  decoded funct3
//  funct7         in   7  decoded funct7 (only bit 5 used)
//  zero           in   1  ALU zero flag
//  mem_ready      in   1  memory completes the current access this cycle
//  pc_write       out  1  load PC
//  adr_src        out  1  mem address: 0=PC, 1=Result
//  mem_write      out  1  memory write strobe
//  ir_write       out  1  load IR and OldPC
//  result_src     out  2  00=ALUOut, 01=Data, 10=ALUResult
//  alu_src_a      out  2  00=PC, 01=OldPC, 10=RD1
//  alu_src_b      out  2  00=RD2, 01=ImmExt, 10=const 4
//  imm_src        out  2  00=I, 01=S, 10=B, 11=J
//  alu_control    out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  reg_write      out  1  register-file write strobe
//  instr_done     out  1  one-cycle pulse on the last state of each instruction
//  state_o        out  4  current state encoding (debug)
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEMADR=2 MEMREAD=3 MEMWB=4 MEMWRITE=5 EXECR=6 EXECI=7
//    ALUWB=8 BEQ=9 JAL=10 TRAP=11. Moore outputs from state; alu_control also uses op/funct.
//  Reset: state=FETCH; while rst_n=0 every output is 0 (all strobes deasserted).
//    Reset mid-instruction aborts it; no partial write is issued after rst_n falls.
//  FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10.
//    Hold while mem_ready=0 (ir_write=pc_write=0). On mem_ready=1: ir_write=pc_write=1, -> DECODE.
//  DECODE: alu_src_a=01, alu_src_b=01, imm_src=10, add (branch target into ALUOut).
//    op 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BEQ, 1101111->JAL, else illegal.
//  MEMADR: alu_src_a=10, alu_src_b=01, add; imm_src=00 (lw) / 01 (sw). lw->MEMREAD, sw->MEMWRITE.
//  MEMREAD: adr_src=1, result_src=00; hold until mem_ready=1, -> MEMWB.
//  MEMWB: result_src=01, reg_write=1, instr_done=1, -> FETCH.
//  MEMWRITE: adr_src=1, result_src=00; mem_write=1 every waiting cycle; on mem_ready=1 instr_done=1, -> FETCH.
//  EXECR: alu_src_a=10, alu_src_b=00. EXECI: alu_src_a=10, alu_src_b=01, imm_src=00. Both -> ALUWB.
//  ALUWB: result_src=00, reg_write=1, instr_done=1, -> FETCH.
//  BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00; pc_write=zero; instr_done=1, -> FETCH.
//  JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1, -> ALUWB (rd=PC+4).
//  alu_control in EXECR/EXECI from funct3: 000 add (sub if R-type and funct7[5]=1),
//    010 slt, 110 or, 111 and, any other funct3 -> add. All other states: as listed.
//  Latency (mem_ready=1): lw 5, sw 4, R/I 4, beq 3, jal 4 cycles.
//  Unused outputs in any state are 0. Never reg_write and mem_write in the same cycle.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: illegal opcode in DECODE -> TRAP; TRAP holds forever with all
//    strobes 0 until rst_n asserted; state_o=11.
//  Not defined: illegal opcode is a NOP; DECODE -> FETCH with instr_done=1; TRAP unreachable.
// TESTING
//  Reset with mem_ready=1, release -> FETCH, cycle 1 pc_write=ir_write=1, state_o 0->1.
//  lw (op=0000011), mem_ready=1 -> states 0,1,2,3,4; reg_write=1 only in state 4; 5 cycles.
//  sw, mem_ready low 3 cycles in MEMWRITE -> mem_write=1 for 4 cycles, instr_done once, no reg_write.
//  R-type funct3=000 funct7=0100000 -> alu_control=001 in EXECR; funct3=111 -> 010.
//  beq zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0; both return to FETCH.
//  op=1111111: with ILLEGAL_TRAP_EN stuck at state 11 until rst_n=0; without, 2-cycle NOP.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: decoder/datapath <-> controller bundle (master = controller)
interface multicycle_control_fsm_if #(
  parameter int OPCODE_WIDTH = 7,
  parameter int FUNCT3_WIDTH = 3,
  parameter int FUNCT7_WIDTH = 7
);
  logic [OPCODE_WIDTH-1:0] op;
  logic [FUNCT3_WIDTH-1:0] funct3;
  logic [FUNCT7_WIDTH-1:0] funct7;
  logic zero;
  logic mem_ready;
  logic pc_write;
  logic adr_src;
  logic mem_write;
  logic ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic reg_write;
  logic instr_done;
  modport master (
    input op, funct3, funct7, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
      imm_src, alu_control, reg_write, instr_done
  );
  modport slave (
    output op, funct3, funct7, zero, mem_ready,
    input pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
      imm_src, alu_control, reg_write, instr_done
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multi-cycle RV32I-subset controller (lw, sw, R, I, beq, jal).
// Define ILLEGAL_TRAP_EN to park illegal opcodes in TRAP; otherwise they retire as NOPs.
module multicycle_control_fsm #(
  parameter int OPCODE_WIDTH = 7,
  parameter int FUNCT3_WIDTH = 3,
  parameter int FUNCT7_WIDTH = 7,
  parameter int STATE_WIDTH  = 4
) (
  input  logic clk,
  input  logic rst_n,
  multicycle_control_fsm_if.master bus,
  output logic [STATE_WIDTH-1:0] state_o
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4, MEMWRITE = 4'd5,
    EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BEQ = 4'd9, JAL = 4'd10, TRAP = 4'd11
  } state_t;
  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       reg_write;
    logic       instr_done;
  } ctl_t;
  localparam logic [OPCODE_WIDTH-1:0] OP_LW  = OPCODE_WIDTH'(7'b0000011);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW  = OPCODE_WIDTH'(7'b0100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_R   = OPCODE_WIDTH'(7'b0110011);
  localparam logic [OPCODE_WIDTH-1:0] OP_I   = OPCODE_WIDTH'(7'b0010011);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ = OPCODE_WIDTH'(7'b1100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_JAL = OPCODE_WIDTH'(7'b1101111);
  state_t state, next;
  ctl_t c, o;
  logic [2:0] exec_alu;
  logic unused_funct7;
  assign unused_funct7 = &{1'b0, bus.funct7[FUNCT7_WIDTH-1:6], bus.funct7[4:0]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FETCH;
    else state <= next;
  // funct3 decode for EXECR/EXECI; only R-type may turn add into sub
  always_comb begin
    exec_alu = 3'b000;
    case (bus.funct3)
      FUNCT3_WIDTH'(3'b000): exec_alu = (state == EXECR && bus.funct7[5]) ? 3'b001 : 3'b000;
      FUNCT3_WIDTH'(3'b010): exec_alu = 3'b101;
      FUNCT3_WIDTH'(3'b110): exec_alu = 3'b011;
      FUNCT3_WIDTH'(3'b111): exec_alu = 3'b010;
      default:               exec_alu = 3'b000;
    endcase
  end
  always_comb begin
    next = state;
    c = '0;
    case (state)
      FETCH: begin
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
        c.ir_write   = bus.mem_ready;
        c.pc_write   = bus.mem_ready;
        next = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
        c.imm_src   = 2'b10;
        if (bus.op == OP_LW || bus.op == OP_SW) next = MEMADR;
        else if (bus.op == OP_R) next = EXECR;
        else if (bus.op == OP_I) next = EXECI;
        else if (bus.op == OP_BEQ) next = BEQ;
        else if (bus.op == OP_JAL) next = JAL;
        else begin
`ifdef ILLEGAL_TRAP_EN
          next = TRAP;
`else
          c.instr_done = 1'b1;
          next = FETCH;
`endif
        end
      end
      MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.imm_src   = (bus.op == OP_SW) ? 2'b01 : 2'b00;
        next = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        c.adr_src = 1'b1;
        next = bus.mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
        next = FETCH;
      end
      MEMWRITE: begin
        c.adr_src    = 1'b1;
        c.mem_write  = 1'b1;
        c.instr_done = bus.mem_ready;
        next = bus.mem_ready ? FETCH : MEMWRITE;
      end
      EXECR: begin
        c.alu_src_a   = 2'b10;
        c.alu_control = exec_alu;
        next = ALUWB;
      end
      EXECI: begin
        c.alu_src_a   = 2'b10;
        c.alu_src_b   = 2'b01;
        c.alu_control = exec_alu;
        next = ALUWB;
      end
      ALUWB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
        next = FETCH;
      end
      BEQ: begin
        c.alu_src_a   = 2'b10;
        c.alu_control = 3'b001;
        c.pc_write    = bus.zero;
        c.instr_done  = 1'b1;
        next = FETCH;
      end
      JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_write  = 1'b1;
        next = ALUWB;
      end
      TRAP: next = TRAP;
      default: next = FETCH;
    endcase
  end
  // gating by rst_n keeps every strobe low the instant reset falls, even mid-cycle
  assign o               = rst_n ? c : '0;
  assign bus.pc_write    = o.pc_write;
  assign bus.adr_src     = o.adr_src;
  assign bus.mem_write   = o.mem_write;
  assign bus.ir_write    = o.ir_write;
  assign bus.result_src  = o.result_src;
  assign bus.alu_src_a   = o.alu_src_a;
  assign bus.alu_src_b   = o.alu_src_b;
  assign bus.imm_src     = o.imm_src;
  assign bus.alu_control = o.alu_control;
  assign bus.reg_write   = o.reg_write;
  assign bus.instr_done  = o.instr_done;
  assign state_o         = STATE_WIDTH'(state);
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: random instruction stream checked against a per-instruction
// expected-state-trace model built from instruction class and injected memory stalls.
module tb_multicycle_control_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] state_o;
  int checks = 0;
  int errors = 0;
  multicycle_control_fsm_if bus();
  multicycle_control_fsm dut (.clk(clk), .rst_n(rst_n), .bus(bus), .state_o(state_o));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_out();
    return {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.result_src,
            bus.alu_src_a, bus.alu_src_b, bus.imm_src, bus.alu_control, bus.reg_write,
            bus.instr_done, state_o};
  endfunction

  function automatic logic [6:0] op_of(input int cls);
    case (cls)
      0: return 7'b0000011;
      1: return 7'b0100011;
      2: return 7'b0110011;
      3: return 7'b0010011;
      4: return 7'b1100011;
      5: return 7'b1101111;
      default: return ($urandom_range(0, 1) != 0) ? 7'b1111111 : 7'b0000000;
    endcase
  endfunction

  function automatic logic [2:0] ref_alu(input logic [2:0] f3, input logic [6:0] f7, input bit is_r);
    if (f3 == 3'b000) return (is_r && f7[5]) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  // cls: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal, 6 illegal; fs/ms = fetch/memory stall cycles
  task automatic run_instr(input int cls, input int fs, input int ms);
    int q[$];
    bit last, mem;
    bus.op     = op_of(cls);
    bus.funct3 = 3'($urandom);
    bus.funct7 = ($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'($urandom);
    bus.zero   = 1'($urandom);
    repeat (fs + 1) q.push_back(0);
    q.push_back(1);
    case (cls)
      0: begin q.push_back(2); repeat (ms + 1) q.push_back(3); q.push_back(4); end
      1: begin q.push_back(2); repeat (ms + 1) q.push_back(5); end
      2: begin q.push_back(6); q.push_back(8); end
      3: begin q.push_back(7); q.push_back(8); end
      4: q.push_back(9);
      5: begin q.push_back(10); q.push_back(8); end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        repeat (4) q.push_back(11);
`endif
      end
    endcase
    for (int i = 0; i < q.size(); i++) begin
      last = (i == q.size() - 1) || (q[i + 1] != q[i]);
      mem  = (q[i] == 0) || (q[i] == 3) || (q[i] == 5);
      bus.mem_ready = mem ? last : 1'($urandom);
      @(negedge clk);
      check("state", 32'(state_o), 32'(q[i]));
      check("reg_write", 32'(bus.reg_write), 32'(q[i] == 4 || q[i] == 8));
      check("mem_write", 32'(bus.mem_write), 32'(q[i] == 5));
      check("adr_src", 32'(bus.adr_src), 32'(q[i] == 3 || q[i] == 5));
      check("ir_write", 32'(bus.ir_write), 32'(q[i] == 0 && last));
      check("pc_write", 32'(bus.pc_write),
            32'((q[i] == 0 && last) || (q[i] == 9 && bus.zero) || q[i] == 10));
      check("instr_done", 32'(bus.instr_done), 32'(i == q.size() - 1 && q[i] != 11));
      check("rw_mw_excl", 32'(bus.reg_write & bus.mem_write), 32'd0);
      if (q[i] == 6 || q[i] == 7)
        check("exec_alu", 32'(bus.alu_control), 32'(ref_alu(bus.funct3, bus.funct7, q[i] == 6)));
      if (q[i] == 9) check("beq_sub", 32'(bus.alu_control), 32'd1);
      if (q[i] == 2) check("memadr_imm", 32'(bus.imm_src), 32'(cls == 1));
      if (q[i] == 4) check("memwb_res", 32'(bus.result_src), 32'd1);
      if (q[i] == 11) check("trap_quiet", all_out() >> 4, 32'd0);
      @(posedge clk);
      #1;
    end
    if (q[q.size() - 1] == 11) begin
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
    end
  endtask

  initial begin
    int guard;
    bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7 = 7'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    @(negedge clk);
    check("reset_outputs", all_out(), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("fetch_muxes", {bus.alu_src_a, bus.alu_src_b, bus.result_src, 1'b0, bus.adr_src}, 8'b00101000);
    check("fetch_strobes", {bus.pc_write, bus.ir_write}, 2'b11);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_instr(0, 0, 0);
    run_instr(1, 0, 3);
    bus.op = 7'b0110011;
    run_instr(2, 1, 0);
    run_instr(4, 0, 0);
    run_instr(5, 2, 0);
    run_instr(6, 0, 0);
    for (int n = 0; n < 300; n++)
      run_instr($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3));
    bus.op = 7'b0100011;
    bus.mem_ready = 1'b0;
    guard = 0;
    while (state_o != 4'd5 && guard < 50) begin
      bus.mem_ready = (state_o == 4'd0);
      @(posedge clk);
      #1 guard++;
    end
    check("reach_memwrite", 32'(state_o), 32'd5);
    bus.mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("abort_outputs", all_out(), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_instr(3, 0, 0);
    run_instr(0, 1, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
